key_loader: RTL and testbench
=============================

# key_loader

Serial key-load stage directly upstream of the SARLock-protected circuit. It shifts a KEY_W-bit key in one bit per handshake and holds the previously committed key stable while a new one loads. It commits the new key atomically and drives the committed value onto the `key` input of the locked design. An optional parity check with failure lockout provides a tamper response.

## Interface
- KEY_W, 8, key width in bits; must match the locked design's key port.
- MAX_FAILS, 3, consecutive parity failures that force LOCKED (used only with KEY_PARITY_EN).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- load_start  in  1  starts (or restarts) a key frame
- sin_valid  in  1  serial bit valid
- sin_data  in  1  serial key bit, MSB first
- sin_ready  out  1  stage accepts a bit
- key  out  KEY_W  committed key to the locked design
- key_valid  out  1  key holds a committed value
- load_done  out  1  one-cycle pulse on commit
- load_err  out  1  one-cycle pulse on abort or parity failure
- busy  out  1  state is not IDLE
- locked  out  1  tamper lockout active

## Operation
- Reset values: key=0, key_valid=0, load_done=0, load_err=0, sin_ready=0, busy=0, locked=0, bit count=0, fail count=0, state=IDLE.
- States: IDLE, SHIFT, PARITY (macro only), COMMIT, LOCKED.
- IDLE:
  - load_start=1 → SHIFT.
  - Shadow register and bit count are cleared on that edge.
- SHIFT:
  - sin_ready=1.
  - Transfer occurs only when sin_valid && sin_ready: shadow <= {shadow[KEY_W-2:0], sin_data}, count++.
  - The transfer that brings count to KEY_W moves the FSM to COMMIT, or to PARITY with the macro.
- COMMIT:
  - sin_ready=0.
  - On the exit edge: key <= shadow, key_valid <= 1, load_done pulses, fail count cleared, → IDLE.
- `key` changes only on a COMMIT exit edge or on entry to LOCKED. It is never partially updated.
- load_start during SHIFT or PARITY:
  - Frame aborts, load_err pulses, shadow and count are cleared, FSM stays in/returns to SHIFT.
  - key and key_valid are unchanged. The fail count is not incremented.
- load_start is ignored in COMMIT and LOCKED.
- Simultaneous load_start and a valid transfer: load_start wins, and the bit is discarded.
- Count width is clog2(KEY_W+1). The count never wraps, because the FSM leaves SHIFT at KEY_W.

## Timing
- One transfer per cycle maximum. sin_valid gaps stall the count with no penalty.
- The edge that accepts the final bit is E0.
  - Without the macro: E1 updates key and key_valid, and load_done is high for the cycle after E1.
  - With the macro: the parity bit is accepted at E1, and the commit happens at E2.
- load_err and load_done are registered and last exactly one cycle. They never assert together.
- busy is a combinational decode of the state.
- rst mid-frame: the next edge returns every register to its reset value, and a previously committed key is lost.

## Configuration
- KEY_PARITY_EN defined:
  - After KEY_W bits, PARITY accepts one more bit, with sin_ready=1.
  - The KEY_W data bits plus the parity bit must have even parity. Match → COMMIT.
  - Mismatch → load_err pulse, key unchanged, fail count++, → IDLE. The fail count saturates at MAX_FAILS.
  - When the fail count reaches MAX_FAILS: → LOCKED. locked=1, key forced to 0, key_valid=0, sin_ready=0.
  - LOCKED is left only by rst.
- KEY_PARITY_EN undefined:
  - No PARITY state and no fail counter. locked is tied to 0.
  - LOCKED is unreachable.

## Structure
- Shared package lock_pkg holds the KEY_W default, the MAX_FAILS default, and the state enum key_ld_state_t.
- One sub-module, key_shift_reg, contains the shadow shift register and bit counter, with clear, shift-enable and full outputs.
- key_loader owns the FSM, the committed key register, the fail counter and the pulse generation.

## Test plan
- Load 1,0,1,0,0,1,0,1 with sin_valid held high → key=8'hA5 and key_valid=1 one edge after the 8th bit; load_done is a single-cycle pulse.
- Same frame with sin_valid low on alternate cycles → identical result; key stays 8'hA5 from the prior load until the commit edge.
- Assert load_start after 4 bits, then send 8'h3C → one load_err pulse, then key=8'h3C; key_valid stays high throughout.
- Assert rst after 5 bits of a load that follows an 8'hA5 commit → key=0, key_valid=0, busy=0 on the next cycle.
- With KEY_PARITY_EN: 8'hA5 with parity 0 → commit. Then three frames with parity 1 → three load_err pulses, then locked=1, key=0, sin_ready=0. load_start is ignored until rst.
- With KEY_PARITY_EN: two parity failures, then one good frame, then two failures → locked stays 0, showing the fail count is cleared by the commit.

Source files
------------

// File: rtl/lock_pkg.sv
// lock_pkg: shared defaults and FSM state type for the key-load stage
package lock_pkg;
    localparam int KEY_W_DEF     = 8;
    localparam int MAX_FAILS_DEF = 3;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_PARITY = 3'd2,
        ST_COMMIT = 3'd3,
        ST_LOCKED = 3'd4
    } key_ld_state_t;
endpackage

// File: rtl/key_shift_reg.sv
// key_shift_reg: shadow shift register and bit counter for the incoming key frame
module key_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         din,
    output logic [W-1:0] shadow,
    output logic         full
);
    localparam int CW = $clog2(W + 1);
    logic [CW-1:0] cnt;
    // full marks the shift that completes the frame, so the FSM can leave SHIFT on that same edge
    assign full = shift_en && (cnt == CW'(W - 1));
    // MSB-first shift; clear has priority so a restart discards a coincident bit
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shadow <= '0;
            cnt    <= '0;
        end else if (shift_en) begin
            shadow <= {shadow[W-2:0], din};
            cnt    <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/key_loader.sv
// key_loader: serial key load with atomic commit; KEY_PARITY_EN adds parity check and tamper lockout
module key_loader
    import lock_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
`ifdef KEY_PARITY_EN
    , parameter int MAX_FAILS = MAX_FAILS_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic             sin_ready,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             load_done,
    output logic             load_err,
    output logic             busy,
    output logic             locked
);
    key_ld_state_t    state;
    logic [KEY_W-1:0] shadow;
    logic             full;
    logic             restart;
    logic             xfer;
`ifdef KEY_PARITY_EN
    localparam int FW = $clog2(MAX_FAILS + 1);
    logic [FW-1:0] fail_cnt;
    assign sin_ready = (state == ST_SHIFT) || (state == ST_PARITY);
    assign locked    = state == ST_LOCKED;
`else
    assign sin_ready = state == ST_SHIFT;
    assign locked    = 1'b0;
`endif
    assign busy    = state != ST_IDLE;
    assign restart = load_start && (state == ST_IDLE || sin_ready);
    assign xfer    = sin_valid && sin_ready && !load_start;

    key_shift_reg #(.W(KEY_W)) u_sr (
        .clk      (clk),
        .rst      (rst),
        .clr      (restart),
        .shift_en (xfer && state == ST_SHIFT),
        .din      (sin_data),
        .shadow   (shadow),
        .full     (full)
    );

    // FSM, committed key register, fail counter and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            key       <= '0;
            key_valid <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
`ifdef KEY_PARITY_EN
            fail_cnt  <= '0;
`endif
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            case (state)
                ST_IDLE: if (load_start) state <= ST_SHIFT;
                ST_SHIFT: begin
                    if (load_start) load_err <= 1'b1;
`ifdef KEY_PARITY_EN
                    else if (full) state <= ST_PARITY;
`else
                    else if (full) state <= ST_COMMIT;
`endif
                end
`ifdef KEY_PARITY_EN
                ST_PARITY: begin
                    if (load_start) begin
                        load_err <= 1'b1;
                        state    <= ST_SHIFT;
                    end else if (xfer) begin
                        if (^{shadow, sin_data} == 1'b0) state <= ST_COMMIT;
                        else begin
                            load_err <= 1'b1;
                            fail_cnt <= fail_cnt + 1'b1;
                            if (fail_cnt == FW'(MAX_FAILS - 1)) begin
                                state     <= ST_LOCKED;
                                key       <= '0;
                                key_valid <= 1'b0;
                            end else state <= ST_IDLE;
                        end
                    end
                end
`endif
                ST_COMMIT: begin
                    key       <= shadow;
                    key_valid <= 1'b1;
                    load_done <= 1'b1;
`ifdef KEY_PARITY_EN
                    fail_cnt  <= '0;
`endif
                    state     <= ST_IDLE;
                end
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader: directed self-checking bench for key_loader (parity section under KEY_PARITY_EN)
module tb_key_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start = 1'b0;
    logic       sin_valid = 1'b0;
    logic       sin_data = 1'b0;
    logic       sin_ready;
    logic [7:0] key;
    logic       key_valid, load_done, load_err, busy, locked;
    int         n_vec = 0;
    int         n_err = 0;

    key_loader #(.KEY_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .sin_valid  (sin_valid),
        .sin_data   (sin_data),
        .sin_ready  (sin_ready),
        .key        (key),
        .key_valid  (key_valid),
        .load_done  (load_done),
        .load_err   (load_err),
        .busy       (busy),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // start a frame and shift 8 bits MSB first; returns with the FSM just past E0
    task automatic send_frame(input logic [7:0] v, input bit gaps);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (gaps) begin
                sin_valid = 1'b0;
                tick();
            end
            sin_valid = 1'b1;
            sin_data  = v[i];
            tick();
        end
        sin_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        sin_valid = 1'b1;
        sin_data  = b;
        tick();
        sin_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_key", key, 8'h00);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_load_done", load_done, 1'b0);
        check("rst_load_err", load_err, 1'b0);
        check("rst_sin_ready", sin_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_locked", locked, 1'b0);

`ifndef KEY_PARITY_EN
        // back-to-back A5 frame
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("shift_busy", busy, 1'b1);
        check("shift_ready", sin_ready, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            sin_valid = 1'b1;
            sin_data  = i[0] ? (i == 7 || i == 5) : (i == 2 || i == 0);
            tick();
        end
        sin_valid = 1'b0;
        check("e0_ready", sin_ready, 1'b0);
        check("e0_key_held", key, 8'h00);
        check("e0_key_valid", key_valid, 1'b0);
        tick();
        check("a5_key", key, 8'hA5);
        check("a5_key_valid", key_valid, 1'b1);
        check("a5_done", load_done, 1'b1);
        tick();
        check("a5_done_pulse", load_done, 1'b0);
        check("a5_idle", busy, 1'b0);

        // same frame with gaps; previous key held until the commit edge
        send_frame(8'hA5, 1'b1);
        check("gap_key_held", key, 8'hA5);
        check("gap_no_done", load_done, 1'b0);
        tick();
        check("gap_key", key, 8'hA5);
        check("gap_done", load_done, 1'b1);

        // abort after 4 bits (with a coincident bit that must be dropped), then 3C
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        load_start = 1'b1;
        sin_valid  = 1'b1;
        sin_data   = 1'b1;
        tick();
        load_start = 1'b0;
        sin_valid  = 1'b0;
        check("abort_err", load_err, 1'b1);
        check("abort_no_done", load_done, 1'b0);
        check("abort_key", key, 8'hA5);
        check("abort_key_valid", key_valid, 1'b1);
        check("abort_busy", busy, 1'b1);
        for (int i = 7; i >= 0; i--) send_bit(((8'h3C >> i) & 1) != 0);
        check("3c_err_pulse", load_err, 1'b0);
        check("3c_key_valid_mid", key_valid, 1'b1);
        tick();
        check("3c_key", key, 8'h3C);
        check("3c_done", load_done, 1'b1);

        // load_start during COMMIT is ignored
        send_frame(8'h5A, 1'b0);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("commit_ign_key", key, 8'h5A);
        check("commit_ign_err", load_err, 1'b0);
        check("commit_ign_busy", busy, 1'b0);

        // A5 commit then rst mid-frame
        send_frame(8'hA5, 1'b0);
        tick();
        check("pre_rst_key", key, 8'hA5);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_key", key, 8'h00);
        check("midrst_key_valid", key_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", sin_ready, 1'b0);
`else
        // good frame: A5 has four ones, parity 0
        send_frame(8'hA5, 1'b0);
        check("par_state_ready", sin_ready, 1'b1);
        send_bit(1'b0);
        check("par_ok_no_err", load_err, 1'b0);
        tick();
        check("par_ok_key", key, 8'hA5);
        check("par_ok_done", load_done, 1'b1);
        for (int f = 0; f < 3; f++) begin
            send_frame(8'hA5, 1'b0);
            send_bit(1'b1);
            check("par_bad_err", load_err, 1'b1);
            check("par_bad_locked", locked, f == 2);
        end
        check("lock_key", key, 8'h00);
        check("lock_key_valid", key_valid, 1'b0);
        check("lock_ready", sin_ready, 1'b0);
        load_start = 1'b1;
        tick();
        tick();
        load_start = 1'b0;
        check("lock_ign_start", locked, 1'b1);
        check("lock_ign_err", load_err, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("unlock_rst", locked, 1'b0);

        // fail, fail, good, fail, fail: commit clears the count
        for (int f = 0; f < 5; f++) begin
            send_frame(8'h3C, 1'b0);
            send_bit(f != 2);
            tick();
        end
        check("clr_locked", locked, 1'b0);
        check("clr_key", key, 8'h3C);
        check("clr_key_valid", key_valid, 1'b1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
